// File: rtl/qpsk_symbol_framer.sv
// QPSK symbol framer: prefixes each frame with an alternating 00/11 preamble, then sends payload bytes as MSB-first dibits.
// Optional payload scrambler (x^7+x^4+1, seed 7'h7F per frame) enabled by defining QPSK_FRAMER_SCRAMBLER_EN.
module qpsk_symbol_framer #(
    parameter int unsigned PREAMBLE_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] bit_out,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       sym_last,
    output logic       underrun
);

    localparam int unsigned CNT_W = (PREAMBLE_LEN > 2) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

    state_t           state_q;
    logic [7:0]       hold_q;
    logic             hold_full_q;
    logic             last_q;
    logic             gap_q;
    logic [CNT_W-1:0] pre_cnt_q;
    logic [1:0]       dib_q;
    logic [1:0]       bit_out_q;
    logic             sym_valid_q;
    logic             sym_last_q;
    logic             underrun_q;
    logic [7:0]       hold_d;
    logic             in_fire;
    logic             sym_fire;

    function automatic logic [1:0] dibit(input logic [7:0] b, input logic [1:0] idx);
        logic [7:0] sh;
        sh = b << {idx, 1'b0};
        return sh[7:6];
    endfunction

`ifdef QPSK_FRAMER_SCRAMBLER_EN
    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    // Whole byte is scrambled on load: eight steps in transmit (MSB-first) order.
    function automatic logic [14:0] scramble(input logic [6:0] seed, input logic [7:0] d);
        logic [6:0] s;
        logic [7:0] dd;
        logic [7:0] o;
        logic       nb;
        s  = seed;
        dd = d;
        o  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            nb = s[6] ^ s[3];
            o  = {o[6:0], dd[7] ^ nb};
            dd = {dd[6:0], 1'b0};
            s  = {s[5:0], nb};
        end
        return {s, o};
    endfunction

    always_comb begin
        {lfsr_d, hold_d} = scramble((state_q == IDLE) ? 7'h7F : lfsr_q, in_data);
    end
`else
    always_comb begin
        hold_d = in_data;
    end
`endif

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                DATA:    in_ready = !last_q && (!hold_full_q ||
                                    (sym_valid_q && sym_ready && (dib_q == 2'd3)));
                default: in_ready = 1'b0;
            endcase
        end
        in_fire  = in_valid && in_ready;
        sym_fire = sym_valid_q && sym_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            last_q      <= 1'b0;
            gap_q       <= 1'b0;
            pre_cnt_q   <= '0;
            dib_q       <= '0;
            bit_out_q   <= '0;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef QPSK_FRAMER_SCRAMBLER_EN
            lfsr_q      <= '0;
`endif
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        state_q     <= PREAMBLE;
                        hold_q      <= hold_d;
                        hold_full_q <= 1'b1;
                        last_q      <= in_last;
                        gap_q       <= 1'b0;
                        pre_cnt_q   <= '0;
                        dib_q       <= '0;
                        bit_out_q   <= 2'b00;
                        sym_valid_q <= 1'b1;
                        sym_last_q  <= 1'b0;
`ifdef QPSK_FRAMER_SCRAMBLER_EN
                        lfsr_q      <= lfsr_d;
`endif
                    end
                end
                PREAMBLE: begin
                    if (sym_fire) begin
                        if (pre_cnt_q == PRE_LAST) begin
                            state_q   <= DATA;
                            bit_out_q <= dibit(hold_q, 2'd0);
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 1'b1;
                            bit_out_q <= {2{~pre_cnt_q[0]}};
                        end
                    end
                end
                DATA: begin
                    if (sym_fire && (dib_q != 2'd3)) begin
                        dib_q      <= dib_q + 2'd1;
                        bit_out_q  <= dibit(hold_q, dib_q + 2'd1);
                        sym_last_q <= last_q && (dib_q == 2'd2);
                    end else if (sym_fire && last_q) begin
                        state_q     <= IDLE;
                        hold_q      <= '0;
                        hold_full_q <= 1'b0;
                        last_q      <= 1'b0;
                        pre_cnt_q   <= '0;
                        dib_q       <= '0;
                        bit_out_q   <= 2'b00;
                        sym_valid_q <= 1'b0;
                        sym_last_q  <= 1'b0;
                    end else if ((sym_fire || !hold_full_q) && in_fire) begin
                        hold_q      <= hold_d;
                        hold_full_q <= 1'b1;
                        last_q      <= in_last;
                        gap_q       <= 1'b0;
                        dib_q       <= '0;
                        bit_out_q   <= hold_d[7:6];
                        sym_valid_q <= 1'b1;
                        sym_last_q  <= 1'b0;
`ifdef QPSK_FRAMER_SCRAMBLER_EN
                        lfsr_q      <= lfsr_d;
`endif
                    end else if (sym_fire) begin
                        hold_q      <= '0;
                        hold_full_q <= 1'b0;
                        dib_q       <= '0;
                        sym_valid_q <= 1'b0;
                    end else if (!hold_full_q && !gap_q) begin
                        // Registered outputs: the first empty cycle is flagged one cycle later.
                        underrun_q <= 1'b1;
                        gap_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_out   = bit_out_q;
    assign sym_valid = sym_valid_q;
    assign sym_last  = sym_last_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_qpsk_symbol_framer.sv
// Directed bench for qpsk_symbol_framer: expected symbols are queued when bytes are accepted and popped as symbols transfer.
// Scrambler expectations follow QPSK_FRAMER_SCRAMBLER_EN when it is defined for the build.
module tb_qpsk_symbol_framer;

    localparam int unsigned PL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [1:0] bit_out;
    logic       sym_valid;
    logic       sym_ready = 1'b1;
    logic       sym_last;
    logic       underrun;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          urun_cnt = 0;
    logic [2:0]  exp_q[$];
    logic [2:0]  mon_e;
    logic        in_frame = 1'b0;
    logic [6:0]  mlfsr = 7'h7F;

    qpsk_symbol_framer #(.PREAMBLE_LEN(PL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .bit_out  (bit_out),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_last (sym_last),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: one entry per transferred symbol.
    always @(negedge clk) begin
        if (rst_n && underrun === 1'b1) urun_cnt++;
        if (rst_n && sym_valid === 1'b1 && sym_ready) begin
            if (exp_q.size() == 0) begin
                check("sym_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("sym_bits", 32'(bit_out), 32'(mon_e[1:0]));
                check("sym_last", 32'(sym_last), 32'(mon_e[2]));
                if (mon_e[2]) check("in_ready_on_last", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic last);
        logic [7:0] s;
        logic       nb;
        if (!in_frame) begin
            for (int i = 0; i < PL; i++) exp_q.push_back({1'b0, (i % 2 == 1) ? 2'b11 : 2'b00});
            mlfsr    = 7'h7F;
            in_frame = 1'b1;
        end
        s = d;
`ifdef QPSK_FRAMER_SCRAMBLER_EN
        for (int i = 7; i >= 0; i--) begin
            nb    = mlfsr[6] ^ mlfsr[3];
            s[i]  = d[i] ^ nb;
            mlfsr = {mlfsr[5:0], nb};
        end
`else
        nb = 1'b0;
`endif
        exp_q.push_back({1'b0, s[7:6]});
        exp_q.push_back({1'b0, s[5:4]});
        exp_q.push_back({1'b0, s[3:2]});
        exp_q.push_back({last & ~nb | last & nb, s[1:0]});
        if (last) in_frame = 1'b0;
    endtask

    task automatic put(input logic [7:0] d, input logic last, output int unsigned acc_cyc);
        int n;
        n        = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("put_timeout", 32'(in_ready), 32'd1);
        else push_byte(d, last);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic drain(output int unsigned end_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        end_cyc = cyc;
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_sym_valid"}, 32'(sym_valid), 32'd0);
        check({tag, "_idle_sym_last"}, 32'(sym_last), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a, b, e, e2;
        int u0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_bit_out", 32'(bit_out), 32'd0);
        check("rst_sym_last", 32'(sym_last), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single byte frame, full rate
        put(8'hB4, 1'b1, a);
        check("first_sym_valid", 32'(sym_valid), 32'd1);
        check("first_sym_bits", 32'(bit_out), 32'd0);
        drain(e);
        check("b4_latency", e - a, 32'(PL + 4));
        idle_check("b4");

        // Back-to-back bytes without a bubble
        put(8'h1B, 1'b0, a);
        put(8'hE4, 1'b1, b);
        check("b2b_accept_cycle", b - a, 32'(PL + 4));
        drain(e);
        check("b2b_latency", e - a, 32'(PL + 8));
        idle_check("b2b");

        // Downstream stall on the fifth preamble symbol
        put(8'h5A, 1'b1, a);
        repeat (4) @(posedge clk);
        #1;
        sym_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(sym_valid), 32'd1);
            check("stall_bits", 32'(bit_out), 32'd0);
            @(posedge clk);
            #1;
        end
        sym_ready = 1'b1;
        drain(e);
        check("stall_latency", e - a, 32'(PL + 4 + 3));
        idle_check("stall");

        // Payload gap of three cycles
        u0 = urun_cnt;
        put(8'hC3, 1'b0, a);
        drain(e);
        check("gap_valid_1", 32'(sym_valid), 32'd0);
        @(posedge clk);
        #1;
        check("gap_valid_2", 32'(sym_valid), 32'd0);
        @(posedge clk);
        #1;
        check("gap_valid_3", 32'(sym_valid), 32'd0);
        put(8'h3C, 1'b1, b);
        check("gap_accept", b - e, 32'd3);
        drain(e2);
        check("gap_resume", e2 - b, 32'd4);
        check("gap_underrun_pulses", 32'(urun_cnt - u0), 32'd1);
        idle_check("gap");

        // Reset during the second data dibit
        put(8'h96, 1'b1, a);
        repeat (PL + 1) @(posedge clk);
        #1;
        sym_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_sym_valid", 32'(sym_valid), 32'd0);
        check("mid_rst_bit_out", 32'(bit_out), 32'd0);
        check("mid_rst_sym_last", 32'(sym_last), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        rst_n     = 1'b1;
        sym_ready = 1'b1;
        exp_q.delete();
        in_frame  = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        put(8'h2D, 1'b1, a);
        check("post_rst_first_valid", 32'(sym_valid), 32'd1);
        check("post_rst_first_bits", 32'(bit_out), 32'd0);
        drain(e);
        check("post_rst_latency", e - a, 32'(PL + 4));
        idle_check("post_rst");

        // Zero payload (shows the keystream when scrambling is enabled)
        put(8'h00, 1'b1, a);
        drain(e);
        check("zero_latency", e - a, 32'(PL + 4));
        idle_check("zero");

        check("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qpsk_symbol_framer.md
QPSK_SYMBOL_FRAMER -- requirements
Module: qpsk_symbol_framer

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 16, number of preamble symbols per frame (legal range 2..255, even).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_data  input  8  payload byte.
REQ-005 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-006 SHALL have port in_last  input  1  byte is the last of its frame.
REQ-007 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port bit_out  output  2  QPSK symbol bits to the downstream mapper.
REQ-009 SHALL have port sym_valid  output  1  bit_out valid.
REQ-010 SHALL have port sym_ready  input  1  downstream accepts a symbol this cycle.
REQ-011 SHALL have port sym_last  output  1  final symbol of the frame.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse on a payload gap.

Function
REQ-013 SHALL transfer a byte when in_valid && in_ready, and a symbol when sym_valid && sym_ready.
REQ-014 SHALL implement states IDLE, PREAMBLE and DATA; the reset state is IDLE.
REQ-015 In IDLE, in_ready SHALL be 1 and sym_valid SHALL be 0; an accepted byte is stored in a holding register, and the state moves to PREAMBLE.
REQ-016 The first preamble symbol SHALL be valid in the cycle after the byte is accepted in IDLE.
REQ-017 In PREAMBLE, the block SHALL emit PREAMBLE_LEN symbols alternating 2'b00, 2'b11, starting with 2'b00, with in_ready=0.
REQ-018 After the last preamble symbol is accepted, the state SHALL move to DATA.
REQ-019 In DATA, the block SHALL emit each held byte as four dibits, MSB first: [7:6], [5:4], [3:2], [1:0].
REQ-020 In DATA, in_ready SHALL be 1 when the holding register is empty, or when dibit [1:0] is being accepted this cycle (combinational on sym_ready). This gives zero-bubble back-to-back bytes.
REQ-021 If in DATA the holding register is empty, the frame has not ended and in_valid=0:
- sym_valid SHALL be 0;
- underrun SHALL pulse for one cycle on the first such cycle only;
- the state SHALL stay DATA.
REQ-022 sym_last SHALL be 1 only with dibit [1:0] of a byte accepted with in_last=1.
REQ-023 Acceptance of the sym_last symbol SHALL return the state to IDLE in the next cycle; in_ready stays 0 during that cycle.
REQ-024 While sym_valid=1 and sym_ready=0, bit_out, sym_valid and sym_last SHALL hold stable; the preamble and dibit counters SHALL NOT advance.
REQ-025 sym_valid, bit_out, sym_last and underrun SHALL depend only on registered state; there is no combinational path from any input.
REQ-026 Counters SHALL be sized for PREAMBLE_LEN and SHALL NOT wrap inside a frame.
REQ-027 in_data SHALL be ignored when no transfer occurs.

Reset
REQ-028 While rst_n=0 at a clk edge, the block SHALL:
- enter IDLE and clear the holding register and counters;
- drive in_ready=0, sym_valid=0, bit_out=2'b00, sym_last=0, underrun=0.
REQ-029 Reset mid-frame SHALL discard the frame with no sym_last emitted; the first cycle after reset release SHALL be IDLE with in_ready=1.

Configuration
REQ-030 With macro QPSK_FRAMER_SCRAMBLER_EN defined, payload bits SHALL be XORed with a Fibonacci LFSR, x^7+x^4+1:
- new bit = s[6]^s[3], shifted in at s[0];
- one LFSR step per data bit, in transmit order;
- seed 7'h7F reloaded at each IDLE-to-PREAMBLE transition;
- preamble symbols are not scrambled.
REQ-031 Without QPSK_FRAMER_SCRAMBLER_EN, payload bits SHALL pass unmodified, and no LFSR logic SHALL be synthesised.

Verification
REQ-032 Scrambler off, PREAMBLE_LEN=16, sym_ready=1, byte 0xB4 with in_last=1 -> first symbol one cycle after acceptance; 00,11 ×8, then 10,11,01,00; sym_last only on the final 00; IDLE next cycle.
REQ-033 Bytes 0x1B then 0xE4 (last), in_valid continuous -> data symbols 00,01,10,11,11,10,01,00 on consecutive cycles; in_ready high with the 4th dibit of 0x1B; no bubble.
REQ-034 sym_ready=0 for 3 cycles on the 5th preamble symbol -> bit_out=00, sym_valid=1 held 3 cycles; total preamble count still 16.
REQ-035 Second byte delayed 3 cycles after the first byte's last dibit -> sym_valid=0 for 3 cycles; underrun high exactly 1 cycle; data resumes with correct dibits.
REQ-036 rst_n=0 for one edge during the 2nd data dibit -> all outputs at reset values next cycle; a following frame starts with a full 16-symbol preamble.
REQ-037 QPSK_FRAMER_SCRAMBLER_EN defined, byte 0x00 (last) -> data symbols 00,00,11,10 (scrambled 0x0E).
